// File: rtl/key_repeat_scanner.sv
// key_repeat_scanner: synchronise, debounce and auto-repeat push buttons into one-cycle step pulses
//
// Ports:
//    CP      clock (10 kHz divided clock intended)
//    CR      synchronous active-high reset
//    KEY_IN  raw asynchronous button levels, high = pressed
//    PULSE   one-hot one-cycle step pulse for the tracked key
//    KEY_ID  index of the tracked key
//    HELD    high while auto-repeating
//    BUSY    high whenever the scanner is not idle
//
// Optional feature macro KEY_REPEAT_ACCEL_EN: after 8 repeat pulses in one
// press the repeat interval halves until release.
module key_repeat_scanner #(
   parameter int KEYS         = 6,
   parameter int DEBOUNCE_CYC = 200,
   parameter int HOLD_CYC     = 8000,
   parameter int REPEAT_CYC   = 2000,
   localparam int IW          = (KEYS > 1) ? $clog2(KEYS) : 1
) (
   input  logic            CP,
   input  logic            CR,
   input  logic [KEYS-1:0] KEY_IN,
   output logic [KEYS-1:0] PULSE,
   output logic [IW-1:0]   KEY_ID,
   output logic            HELD,
   output logic            BUSY
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_DEB  = 3'd1;
   localparam logic [2:0] S_HOLD = 3'd2;
   localparam logic [2:0] S_REP  = 3'd3;
   localparam logic [2:0] S_REL  = 3'd4;
   localparam logic [15:0] D_M1 = 16'(DEBOUNCE_CYC - 1);
   localparam logic [15:0] H_M1 = 16'(HOLD_CYC - 1);
   localparam logic [15:0] R_M1 = 16'(REPEAT_CYC - 1);
   localparam logic [KEYS-1:0] ONE = KEYS'(1);

   logic [KEYS-1:0] r_s1, r_s2;
   logic [2:0]      r_state, w_nstate;
   logic [15:0]     r_cnt, w_ncnt, w_last;
   logic [IW-1:0]   r_id, w_low;
   logic            w_kid, w_fire, w_wrap;

   assign w_kid  = r_s2[r_id];
   assign w_fire = (r_state == S_HOLD || r_state == S_REP) && r_cnt == 16'd0;
   assign w_wrap = r_state == S_REP && r_cnt >= w_last;

`ifdef KEY_REPEAT_ACCEL_EN
   localparam logic [15:0] R2_M1 = 16'(REPEAT_CYC / 2 - 1);
   logic [3:0] r_rep;
   assign w_last = (r_rep >= 4'd8) ? R2_M1 : R_M1;
   // Counts repeat pulses of the current press; saturates once acceleration kicks in.
   always_ff @(posedge CP)
      if (CR || r_state != S_REP) r_rep <= '0;
      else if (w_fire && r_rep < 4'd8) r_rep <= r_rep + 4'd1;
`else
   assign w_last = R_M1;
`endif

   // Lowest-index pressed key wins when several are high together.
   always_comb begin
      w_low = '0;
      for (int i = KEYS - 1; i >= 0; i--)
         if (r_s2[i]) w_low = IW'(i);
   end

   always_comb begin
      w_nstate = r_state;
      case (r_state)
         S_IDLE:  w_nstate = |r_s2 ? S_DEB : S_IDLE;
         S_DEB:   w_nstate = !w_kid ? S_IDLE : (r_cnt == D_M1) ? S_HOLD : S_DEB;
         S_HOLD:  w_nstate = !w_kid ? S_REL : (r_cnt == H_M1) ? S_REP : S_HOLD;
         S_REP:   w_nstate = !w_kid ? S_REL : S_REP;
         S_REL:   w_nstate = (!w_kid && r_cnt == D_M1) ? S_IDLE : S_REL;
         default: w_nstate = S_IDLE;
      endcase
   end

   // Counter clears on every state entry, on each repeat period and on any
   // high sample while waiting for a clean release.
   assign w_ncnt = (w_nstate != r_state || r_state == S_IDLE || w_wrap ||
                    (r_state == S_REL && w_kid)) ? 16'd0 : r_cnt + 16'd1;

   always_ff @(posedge CP)
      if (CR) begin
         r_s1    <= '0;
         r_s2    <= '0;
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_id    <= '0;
      end else begin
         r_s1    <= KEY_IN;
         r_s2    <= r_s1;
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
         if (r_state == S_IDLE && |r_s2) r_id <= w_low;
      end

   assign PULSE  = w_fire ? ONE << r_id : '0;
   assign KEY_ID = r_id;
   assign HELD   = r_state == S_REP;
   assign BUSY   = r_state != S_IDLE;
endmodule

// File: tb/tb_key_repeat_scanner.sv
// tb_key_repeat_scanner: scoreboard bench for key_repeat_scanner with short timing parameters
module tb_key_repeat_scanner;
   localparam int K = 6, D = 4, H = 20, R = 5;

   typedef struct {
      int           cyc;
      logic [K-1:0] val;
   } exp_t;

   logic         CP = 1'b0, CR = 1'b1;
   logic [K-1:0] KEY_IN = '0;
   logic [K-1:0] PULSE;
   logic [2:0]   KEY_ID;
   logic         HELD, BUSY;
   exp_t         q[$];
   int           cyc = 0, total = 0, bad = 0;
   int           t;

   key_repeat_scanner #(.KEYS(K), .DEBOUNCE_CYC(D), .HOLD_CYC(H), .REPEAT_CYC(R)) dut (
      .CP(CP), .CR(CR), .KEY_IN(KEY_IN), .PULSE(PULSE), .KEY_ID(KEY_ID), .HELD(HELD), .BUSY(BUSY)
   );

   always #5 CP = ~CP;
   always @(posedge CP) cyc <= cyc + 1;

   // Every cycle PULSE must equal the queued expectation for that cycle, else zero.
   always @(negedge CP) begin
      logic [K-1:0] e;
      e = '0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
         e = q[0].val;
         void'(q.pop_front());
      end
      total++;
      assert (PULSE === e) else begin
         bad++;
         $error("FAIL pulse cyc=%0d got=%b exp=%b", cyc, PULSE, e);
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   // Key first sampled at edge t0 and held for len samples: a pulse at edge p
   // exists only while the key is still seen high there (p <= t0+len+1).
   task automatic press_exp(input int t0, input int len, input int key);
      int p, n;
      logic [K-1:0] v;
      v = '0;
      v[key] = 1'b1;
      if (t0 + 6 <= t0 + len + 1) q.push_back('{t0 + 6, v});
      p = t0 + 6 + H;
      n = 0;
      while (p <= t0 + len + 1) begin
         q.push_back('{p, v});
         n++;
`ifdef KEY_REPEAT_ACCEL_EN
         p += (n >= 8) ? R / 2 : R;
`else
         p += R;
`endif
      end
   endtask

   task automatic start(input int key, input int len, output int t0);
      t0 = cyc + 1;
      KEY_IN[key] = 1'b1;
      press_exp(t0, len, key);
   endtask

   initial begin
      repeat (2) @(negedge CP);
      chk("rst_pulse", PULSE, 0);
      chk("rst_id", KEY_ID, 0);
      chk("rst_held", HELD, 0);
      chk("rst_busy", BUSY, 0);
      CR = 1'b0;
      @(negedge CP);
      // bounce reject
      start(2, 3, t);
      repeat (3) @(negedge CP);
      KEY_IN = '0;
      chk("bounce_busy", BUSY, 1);
      repeat (6) @(negedge CP);
      chk("bounce_idle", BUSY, 0);
      chk("bounce_held", HELD, 0);
      // clean short press
      start(0, 10, t);
      repeat (10) @(negedge CP);
      KEY_IN = '0;
      chk("short_id", KEY_ID, 0);
      chk("short_held", HELD, 0);
      repeat (6) @(negedge CP);
      chk("short_busy_hi", BUSY, 1);
      @(negedge CP);
      chk("short_busy_lo", BUSY, 0);
      repeat (3) @(negedge CP);
      // long press with auto-repeat
      start(4, 70, t);
      repeat (26) @(negedge CP);
      chk("long_held_pre", HELD, 0);
      @(negedge CP);
      chk("long_held_on", HELD, 1);
      chk("long_id", KEY_ID, 4);
      repeat (43) @(negedge CP);
      KEY_IN = '0;
      repeat (2) @(negedge CP);
      chk("long_held_last", HELD, 1);
      @(negedge CP);
      chk("long_held_off", HELD, 0);
      chk("long_busy", BUSY, 1);
      repeat (8) @(negedge CP);
      chk("long_idle", BUSY, 0);
      // simultaneous keys, key 3 still held after key 1 releases
      t = cyc + 1;
      KEY_IN = 6'b001010;
      q.push_back('{t + 6, 6'b000010});
      q.push_back('{t + 21, 6'b001000});
      repeat (10) @(negedge CP);
      chk("simul_id1", KEY_ID, 1);
      KEY_IN = 6'b001000;
      repeat (16) @(negedge CP);
      chk("simul_id3", KEY_ID, 3);
      repeat (4) @(negedge CP);
      KEY_IN = '0;
      repeat (10) @(negedge CP);
      chk("simul_idle", BUSY, 0);
      chk("simul_keep_id", KEY_ID, 3);
      // reset in the middle of auto-repeat with the key still held
      t = cyc + 1;
      KEY_IN[4] = 1'b1;
      q.push_back('{t + 6, 6'b010000});
      q.push_back('{t + 26, 6'b010000});
      q.push_back('{t + 31, 6'b010000});
      repeat (34) @(negedge CP);
      chk("rep_held_before", HELD, 1);
      CR = 1'b1;
      @(negedge CP);
      CR = 1'b0;
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_held", HELD, 0);
      chk("mid_rst_id", KEY_ID, 0);
      press_exp(t + 35, 10, 4);
      repeat (10) @(negedge CP);
      chk("after_rst_busy", BUSY, 1);
      chk("after_rst_id", KEY_ID, 4);
      KEY_IN = '0;
      repeat (12) @(negedge CP);
      chk("final_idle", BUSY, 0);
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
